// File: rtl/rw_memory.sv
// ---------------------------------------------------------------------------
// rw_memory
//   Byte-addressed little-endian read/write memory with byte, half and word
//   accesses at any alignment. An access whose bytes all fall inside one
//   aligned 32-bit word completes in a single cycle. An access that crosses a
//   word boundary takes two cycles: the first-word bytes move at the accept
//   edge and the next-word bytes move at the following (SPLIT) edge.
//   Addresses wrap modulo 2**ADDR_WIDTH. Reads are extended to 32 bits.
//
// Handshake:
//   A request is accepted on a rising edge where i_Req=1 and o_Ready=1; every
//   request input is sampled only at that edge. o_Ready is low only in SPLIT,
//   and requests seen there are dropped, not queued. o_RdValid is a one-cycle
//   pulse with o_RdData valid in that cycle; o_RdData then holds until the
//   next read completes. o_Err is a one-cycle pulse for a reserved size.
//
// Ports:
//   i_Clock      clock, rising edge
//   i_Reset      asynchronous active-high reset (memory contents are kept)
//   i_Req        access request
//   i_WrEnable   1 = write, 0 = read
//   i_Access     size: 00 byte, 01 half, 10 word, 11 reserved
//   i_Unsigned   1 = zero-extend, 0 = sign-extend byte/half reads
//   i_Addr       byte address
//   i_WrData     write data, low bytes used
//   o_Ready      request can be accepted
//   o_RdValid    read completion pulse
//   o_RdData     read result
//   o_Err        reserved-size pulse
//   o_DbgState   state observation: 0 = IDLE, 1 = SPLIT
// ---------------------------------------------------------------------------
module rw_memory #(
    parameter int    DATA_WIDTH = 32,   // only 32 is supported
    parameter int    ADDR_WIDTH = 10,
    parameter string FILE_NAME  = ""
) (
    input  logic                  i_Clock,
    input  logic                  i_Reset,
    input  logic                  i_Req,
    input  logic                  i_WrEnable,
    input  logic [1:0]            i_Access,
    input  logic                  i_Unsigned,
    input  logic [ADDR_WIDTH-1:0] i_Addr,
    input  logic [DATA_WIDTH-1:0] i_WrData,
    output logic                  o_Ready,
    output logic                  o_RdValid,
    output logic [DATA_WIDTH-1:0] o_RdData,
    output logic                  o_Err,
    output logic                  o_DbgState
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SPLIT = 1'b1
    } state_t;

    logic [7:0] r_Mem [0:DEPTH-1];

    state_t                  r_State;
    logic                    r_Ready;
    logic [ADDR_WIDTH-1:0]   r_Addr;
    logic [DATA_WIDTH-1:0]   r_WrData;
    logic                    r_WrEnable;
    logic                    r_Unsigned;
    logic [2:0]              r_Len;      // total bytes of the pending split access
    logic [2:0]              r_P1Cnt;    // bytes already moved at the accept edge
    logic [DATA_WIDTH-1:0]   r_RdBuf;    // first-word bytes of a split read

    logic                    w_Accept;
    logic                    w_Reserved;
    logic [2:0]              w_Len;
    logic                    w_Split;
    logic [2:0]              w_P1Cnt;
    logic [ADDR_WIDTH-1:0]   w_LaneAddr1 [4];
    logic [ADDR_WIDTH-1:0]   w_LaneAddr2 [4];
    logic [DATA_WIDTH-1:0]   w_Gather1;
    logic [DATA_WIDTH-1:0]   w_Gather2;

    // Requests arriving while reset is held are not taken.
    assign w_Accept   = i_Req && r_Ready && !i_Reset;
    assign w_Reserved = (i_Access == 2'b11);

    always_comb begin
        case (i_Access)
            2'b00:   w_Len = 3'd1;
            2'b01:   w_Len = 3'd2;
            2'b10:   w_Len = 3'd4;
            default: w_Len = 3'd0;
        endcase
    end

    // Crossing a word boundary: offset + n - 1 > 3, i.e. offset + n > 4.
    assign w_Split = !w_Reserved && (({1'b0, i_Addr[1:0]} + w_Len) > 3'd4);
    // Bytes moved at the accept edge: all of them, or those left in the first word.
    assign w_P1Cnt = w_Split ? (3'd4 - {1'b0, i_Addr[1:0]}) : w_Len;

    // Byte lane k of an access lives at address + k (wrapping). Phase 1 lanes
    // come from the live request, phase 2 lanes from the captured request.
    always_comb begin
        w_Gather1 = '0;
        w_Gather2 = r_RdBuf;
        for (int k = 0; k < 4; k++) begin
            w_LaneAddr1[k] = i_Addr + ADDR_WIDTH'(k);
            w_LaneAddr2[k] = r_Addr + ADDR_WIDTH'(k);
            if (3'(k) < w_P1Cnt) begin
                w_Gather1[8*k +: 8] = r_Mem[w_LaneAddr1[k]];
            end
            if ((3'(k) >= r_P1Cnt) && (3'(k) < r_Len)) begin
                w_Gather2[8*k +: 8] = r_Mem[w_LaneAddr2[k]];
            end
        end
    end

    function automatic logic [DATA_WIDTH-1:0] extend(input logic [DATA_WIDTH-1:0] d,
                                                     input logic [2:0] len,
                                                     input logic uns);
        case (len)
            3'd1:    return uns ? {24'h0, d[7:0]}   : {{24{d[7]}}, d[7:0]};
            3'd2:    return uns ? {16'h0, d[15:0]}  : {{16{d[15]}}, d[15:0]};
            default: return d;
        endcase
    endfunction

    // Memory array: no reset, so contents survive i_Reset. The second-word
    // write of a split access happens only if SPLIT is still live at that edge,
    // which is how a reset during SPLIT aborts it.
    always @(posedge i_Clock) begin
        if (w_Accept && i_WrEnable && !w_Reserved) begin
            for (int k = 0; k < 4; k++) begin
                if (3'(k) < w_P1Cnt) begin
                    r_Mem[w_LaneAddr1[k]] <= i_WrData[8*k +: 8];
                end
            end
        end else if ((r_State == ST_SPLIT) && r_WrEnable && !i_Reset) begin
            for (int k = 0; k < 4; k++) begin
                if ((3'(k) >= r_P1Cnt) && (3'(k) < r_Len)) begin
                    r_Mem[w_LaneAddr2[k]] <= r_WrData[8*k +: 8];
                end
            end
        end
    end

    // Control FSM with registered outputs.
    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            r_State    <= ST_IDLE;
            r_Ready    <= 1'b1;
            o_RdValid  <= 1'b0;
            o_Err      <= 1'b0;
            o_RdData   <= '0;
            r_Addr     <= '0;
            r_WrData   <= '0;
            r_WrEnable <= 1'b0;
            r_Unsigned <= 1'b0;
            r_Len      <= 3'd0;
            r_P1Cnt    <= 3'd0;
            r_RdBuf    <= '0;
        end else begin
            o_RdValid <= 1'b0;
            o_Err     <= 1'b0;
            case (r_State)
                ST_IDLE: begin
                    if (w_Accept) begin
                        if (w_Reserved) begin
                            o_Err <= 1'b1;
                        end else if (w_Split) begin
                            r_State    <= ST_SPLIT;
                            r_Ready    <= 1'b0;
                            r_Addr     <= i_Addr;
                            r_WrData   <= i_WrData;
                            r_WrEnable <= i_WrEnable;
                            r_Unsigned <= i_Unsigned;
                            r_Len      <= w_Len;
                            r_P1Cnt    <= w_P1Cnt;
                            r_RdBuf    <= w_Gather1;
                        end else if (!i_WrEnable) begin
                            o_RdValid <= 1'b1;
                            o_RdData  <= extend(w_Gather1, w_Len, i_Unsigned);
                        end
                    end
                end
                ST_SPLIT: begin
                    r_State <= ST_IDLE;
                    r_Ready <= 1'b1;
                    if (!r_WrEnable) begin
                        o_RdValid <= 1'b1;
                        o_RdData  <= extend(w_Gather2, r_Len, r_Unsigned);
                    end
                end
                default: begin
                    r_State <= ST_IDLE;
                    r_Ready <= 1'b1;
                end
            endcase
        end
    end

    assign o_Ready    = r_Ready;
    assign o_DbgState = r_State;

endmodule

// File: tb/tb_rw_memory.sv
// ---------------------------------------------------------------------------
// tb_rw_memory
//   Self-checking bench for rw_memory. A byte-array model of the memory gives
//   expected read values, latencies and busy cycles from the access rules.
// ---------------------------------------------------------------------------
module tb_rw_memory;

  localparam int DEPTH = 1024;

  logic        i_Clock;
  logic        i_Reset;
  logic        i_Req;
  logic        i_WrEnable;
  logic [1:0]  i_Access;
  logic        i_Unsigned;
  logic [9:0]  i_Addr;
  logic [31:0] i_WrData;
  logic        o_Ready;
  logic        o_RdValid;
  logic [31:0] o_RdData;
  logic        o_Err;
  logic        o_DbgState;

  int checks = 0;
  int failures = 0;

  logic [7:0] mem_model [DEPTH];

  rw_memory #(.DATA_WIDTH(32), .ADDR_WIDTH(10), .FILE_NAME("")) dut (
    .i_Clock(i_Clock), .i_Reset(i_Reset), .i_Req(i_Req), .i_WrEnable(i_WrEnable),
    .i_Access(i_Access), .i_Unsigned(i_Unsigned), .i_Addr(i_Addr), .i_WrData(i_WrData),
    .o_Ready(o_Ready), .o_RdValid(o_RdValid), .o_RdData(o_RdData), .o_Err(o_Err),
    .o_DbgState(o_DbgState)
  );

  // clock / reset
  initial i_Clock = 1'b0;
  always #5 i_Clock = ~i_Clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // reference model
  function automatic int size_of(input logic [1:0] acc);
    case (acc)
      2'b00: return 1;
      2'b01: return 2;
      2'b10: return 4;
      default: return 0;
    endcase
  endfunction

  function automatic bit is_split(input int addr, input int n);
    return ((addr % 4) + n - 1) > 3;
  endfunction

  function automatic logic [31:0] model_read(input int addr, input int n, input bit uns);
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < n; i++) v[8*i +: 8] = mem_model[(addr + i) % DEPTH];
    if (!uns && n == 1 && v[7]) v[31:8] = '1;
    if (!uns && n == 2 && v[15]) v[31:16] = '1;
    return v;
  endfunction

  task automatic model_write(input int addr, input int n, input logic [31:0] wd);
    for (int i = 0; i < n; i++) mem_model[(addr + i) % DEPTH] = wd[8*i +: 8];
  endtask

  // driver tasks (called at a negedge, return at a negedge with o_Ready expected high)
  task automatic read_op(input logic [1:0] acc, input logic uns, input logic [9:0] addr,
                         output logic [31:0] data, output int lat);
    i_Req = 1'b1; i_WrEnable = 1'b0; i_Access = acc; i_Unsigned = uns;
    i_Addr = addr; i_WrData = $urandom();
    @(negedge i_Clock);
    i_Req = 1'b0;
    lat = 0;
    data = '0;
    for (int c = 1; c <= 2; c++) begin
      if (o_RdValid === 1'b1) begin
        lat = c;
        data = o_RdData;
        break;
      end
      if (c < 2) @(negedge i_Clock);
    end
    for (int w = 0; w < 4 && o_Ready !== 1'b1; w++) @(negedge i_Clock);
  endtask

  // While the DUT is busy a junk write stays requested; it must be dropped.
  task automatic write_op(input logic [1:0] acc, input logic [9:0] addr, input logic [31:0] wd,
                          output int busy, output bit rdv);
    i_Req = 1'b1; i_WrEnable = 1'b1; i_Access = acc; i_Unsigned = 1'($urandom_range(0, 1));
    i_Addr = addr; i_WrData = wd;
    @(negedge i_Clock);
    busy = 0;
    rdv = 1'b0;
    i_Addr = 10'($urandom()); i_WrData = $urandom(); i_Access = 2'($urandom_range(0, 2));
    while (o_Ready !== 1'b1 && busy < 4) begin
      if (o_RdValid === 1'b1) rdv = 1'b1;
      busy++;
      @(negedge i_Clock);
    end
    if (o_RdValid === 1'b1) rdv = 1'b1;
    i_Req = 1'b0;
  endtask

  task automatic init_mem();
    int busy;
    bit rdv;
    logic [31:0] wd;
    for (int w = 0; w < DEPTH / 4; w++) begin
      wd = $urandom();
      write_op(2'b10, 10'(w * 4), wd, busy, rdv);
      model_write(w * 4, 4, wd);
    end
  endtask

  // tests
  task automatic test_reset();
    i_Reset = 1'b1; i_Req = 1'b0; i_WrEnable = 1'b0; i_Access = 2'b00;
    i_Unsigned = 1'b0; i_Addr = '0; i_WrData = '0;
    repeat (2) @(negedge i_Clock);
    checks++; if (o_Ready !== 1'b1) begin failures++; $display("FAIL reset_ready: got %b expected 1", o_Ready); end
    checks++; if (o_RdValid !== 1'b0) begin failures++; $display("FAIL reset_rdvalid: got %b expected 0", o_RdValid); end
    checks++; if (o_Err !== 1'b0) begin failures++; $display("FAIL reset_err: got %b expected 0", o_Err); end
    checks++; if (o_RdData !== 32'h0) begin failures++; $display("FAIL reset_rddata: got %h expected 0", o_RdData); end
    i_Reset = 1'b0;
    @(negedge i_Clock);
  endtask

  task automatic test_word_rw();
    int busy, lat; bit rdv; logic [31:0] d;
    write_op(2'b10, 10'h010, 32'h11223344, busy, rdv);
    model_write('h010, 4, 32'h11223344);
    checks++; if (busy != 0 || rdv) begin failures++; $display("FAIL word_write: busy %0d rdv %b expected 0 0", busy, rdv); end
    read_op(2'b10, 1'b0, 10'h010, d, lat);
    checks++; if (d !== 32'h11223344 || lat != 1) begin failures++; $display("FAIL word_read: got %h lat %0d expected 11223344 lat 1", d, lat); end
    read_op(2'b00, 1'b0, 10'h013, d, lat);
    checks++; if (d !== 32'h00000011 || lat != 1) begin failures++; $display("FAIL byte_read: got %h lat %0d expected 00000011 lat 1", d, lat); end
  endtask

  task automatic test_extension();
    int busy, lat; bit rdv; logic [31:0] d;
    write_op(2'b00, 10'h020, 32'hFFFFFF80, busy, rdv);
    model_write('h020, 1, 32'h80);
    read_op(2'b00, 1'b0, 10'h020, d, lat);
    checks++; if (d !== 32'hFFFFFF80) begin failures++; $display("FAIL sext_byte: got %h expected ffffff80", d); end
    read_op(2'b00, 1'b1, 10'h020, d, lat);
    checks++; if (d !== 32'h00000080) begin failures++; $display("FAIL zext_byte: got %h expected 00000080", d); end
    write_op(2'b01, 10'h030, 32'h12348001, busy, rdv);
    model_write('h030, 2, 32'h8001);
    read_op(2'b01, 1'b0, 10'h030, d, lat);
    checks++; if (d !== 32'hFFFF8001) begin failures++; $display("FAIL sext_half: got %h expected ffff8001", d); end
    read_op(2'b01, 1'b1, 10'h030, d, lat);
    checks++; if (d !== 32'h00008001) begin failures++; $display("FAIL zext_half: got %h expected 00008001", d); end
  endtask

  task automatic test_split();
    int busy, lat; bit rdv; logic [31:0] d;
    logic [7:0] exp_b [4];
    exp_b[0] = 8'hDD; exp_b[1] = 8'hCC; exp_b[2] = 8'hBB; exp_b[3] = 8'hAA;
    write_op(2'b10, 10'h023, 32'hAABBCCDD, busy, rdv);
    model_write('h023, 4, 32'hAABBCCDD);
    checks++; if (busy != 1 || rdv) begin failures++; $display("FAIL split_busy: busy %0d rdv %b expected 1 0", busy, rdv); end
    for (int i = 0; i < 4; i++) begin
      read_op(2'b00, 1'b1, 10'(32'h023 + i), d, lat);
      checks++; if (d !== {24'h0, exp_b[i]}) begin failures++; $display("FAIL split_byte%0d: got %h expected %h", i, d, exp_b[i]); end
    end
    read_op(2'b10, 1'b0, 10'h023, d, lat);
    checks++; if (d !== 32'hAABBCCDD || lat != 2) begin failures++; $display("FAIL split_read: got %h lat %0d expected aabbccdd lat 2", d, lat); end
  endtask

  task automatic test_back_to_back();
    int busy, lat; bit rdv; logic [31:0] d;
    write_op(2'b10, 10'h040, 32'hCAFEF00D, busy, rdv);
    model_write('h040, 4, 32'hCAFEF00D);
    read_op(2'b10, 1'b0, 10'h040, d, lat);
    checks++; if (d !== 32'hCAFEF00D || lat != 1) begin failures++; $display("FAIL b2b_contained: got %h lat %0d expected cafef00d lat 1", d, lat); end
    write_op(2'b10, 10'h046, 32'h01020304, busy, rdv);
    model_write('h046, 4, 32'h01020304);
    read_op(2'b01, 1'b1, 10'h047, d, lat);
    checks++; if (d !== model_read('h047, 2, 1'b1) || lat != 2) begin failures++; $display("FAIL b2b_split: got %h lat %0d expected %h lat 2", d, lat, model_read('h047, 2, 1'b1)); end
  endtask

  task automatic test_wrap();
    int busy, lat; bit rdv; logic [31:0] d;
    write_op(2'b01, 10'h3FF, 32'h0000BEEF, busy, rdv);
    model_write('h3FF, 2, 32'hBEEF);
    checks++; if (busy != 1) begin failures++; $display("FAIL wrap_busy: got %0d expected 1", busy); end
    read_op(2'b00, 1'b1, 10'h3FF, d, lat);
    checks++; if (d !== 32'h000000EF) begin failures++; $display("FAIL wrap_byte3ff: got %h expected 000000ef", d); end
    read_op(2'b00, 1'b1, 10'h000, d, lat);
    checks++; if (d !== 32'h000000BE) begin failures++; $display("FAIL wrap_byte000: got %h expected 000000be", d); end
    read_op(2'b01, 1'b1, 10'h3FF, d, lat);
    checks++; if (d !== 32'h0000BEEF || lat != 2) begin failures++; $display("FAIL wrap_half: got %h lat %0d expected 0000beef lat 2", d, lat); end
  endtask

  task automatic test_reserved();
    int lat; logic [31:0] d;
    read_op(2'b10, 1'b0, 10'h010, d, lat);
    for (int pass = 0; pass < 2; pass++) begin
      i_Req = 1'b1; i_WrEnable = 1'(pass); i_Access = 2'b11; i_Unsigned = 1'b0;
      i_Addr = 10'h010; i_WrData = 32'hDEADBEEF;
      @(negedge i_Clock);
      i_Req = 1'b0;
      checks++; if (o_Err !== 1'b1) begin failures++; $display("FAIL rsv_err%0d: got %b expected 1", pass, o_Err); end
      checks++; if (o_RdValid !== 1'b0) begin failures++; $display("FAIL rsv_rdvalid%0d: got %b expected 0", pass, o_RdValid); end
      checks++; if (o_RdData !== 32'h11223344) begin failures++; $display("FAIL rsv_rddata%0d: got %h expected 11223344", pass, o_RdData); end
      @(negedge i_Clock);
      checks++; if (o_Err !== 1'b0) begin failures++; $display("FAIL rsv_err_pulse%0d: got %b expected 0", pass, o_Err); end
    end
    read_op(2'b10, 1'b0, 10'h010, d, lat);
    checks++; if (d !== 32'h11223344) begin failures++; $display("FAIL rsv_mem: got %h expected 11223344", d); end
  endtask

  task automatic test_reset_split();
    int busy, lat; bit rdv; logic [31:0] d;
    write_op(2'b10, 10'h020, 32'h0, busy, rdv);
    write_op(2'b10, 10'h024, 32'h0, busy, rdv);
    model_write('h020, 8, 32'h0);
    model_write('h024, 4, 32'h0);
    i_Req = 1'b1; i_WrEnable = 1'b1; i_Access = 2'b10; i_Unsigned = 1'b0;
    i_Addr = 10'h023; i_WrData = 32'hAABBCCDD;
    @(negedge i_Clock);
    i_Req = 1'b0;
    checks++; if (o_Ready !== 1'b0 || o_DbgState !== 1'b1) begin failures++; $display("FAIL rst_split_state: ready %b state %b expected 0 1", o_Ready, o_DbgState); end
    i_Reset = 1'b1;
    #1;
    checks++; if (o_Ready !== 1'b1 || o_DbgState !== 1'b0) begin failures++; $display("FAIL rst_split_async: ready %b state %b expected 1 0", o_Ready, o_DbgState); end
    checks++; if (o_RdValid !== 1'b0 || o_RdData !== 32'h0) begin failures++; $display("FAIL rst_split_outs: rdvalid %b rddata %h expected 0 0", o_RdValid, o_RdData); end
    @(negedge i_Clock);
    checks++; if (o_RdValid !== 1'b0) begin failures++; $display("FAIL rst_split_novalid: got %b expected 0", o_RdValid); end
    i_Reset = 1'b0;
    mem_model['h023] = 8'hDD;
    read_op(2'b10, 1'b1, 10'h020, d, lat);
    checks++; if (d !== 32'hDD000000) begin failures++; $display("FAIL rst_split_w0: got %h expected dd000000", d); end
    read_op(2'b10, 1'b1, 10'h024, d, lat);
    checks++; if (d !== 32'h00000000) begin failures++; $display("FAIL rst_split_w1: got %h expected 00000000", d); end
  endtask

  task automatic test_random();
    logic [31:0] exp_q[$];
    logic [31:0] last_rd, d, exp;
    logic [1:0] acc;
    logic [9:0] addr;
    logic uns;
    int n, busy, lat, exp_lat;
    bit rdv;
    exp_q.push_back(model_read('h010, 4, 1'b0));
    read_op(2'b10, 1'b0, 10'h010, last_rd, lat);
    exp = exp_q.pop_front();
    checks++; if (last_rd !== exp) begin failures++; $display("FAIL rnd_seed_read: got %h expected %h", last_rd, exp); end
    last_rd = exp;
    for (int t = 0; t < 400; t++) begin
      acc = 2'($urandom_range(0, 3));
      addr = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(1020, 1023)) : 10'($urandom_range(0, 1023));
      uns = 1'($urandom_range(0, 1));
      n = size_of(acc);
      if (acc == 2'b11) begin
        i_Req = 1'b1; i_WrEnable = 1'($urandom_range(0, 1)); i_Access = acc;
        i_Unsigned = uns; i_Addr = addr; i_WrData = $urandom();
        @(negedge i_Clock);
        i_Req = 1'b0;
        checks++; if (o_Err !== 1'b1 || o_RdValid !== 1'b0 || o_RdData !== last_rd) begin
          failures++; $display("FAIL rnd_reserved t%0d: err %b rdvalid %b rddata %h expected 1 0 %h", t, o_Err, o_RdValid, o_RdData, last_rd);
        end
        @(negedge i_Clock);
      end else if ($urandom_range(0, 1) == 1) begin
        d = $urandom();
        write_op(acc, addr, d, busy, rdv);
        model_write(int'(addr), n, d);
        checks++; if (busy != int'(is_split(int'(addr), n)) || rdv) begin
          failures++; $display("FAIL rnd_write t%0d addr %h size %0d: busy %0d rdv %b expected %0d 0", t, addr, n, busy, rdv, int'(is_split(int'(addr), n)));
        end
      end else begin
        exp_q.push_back(model_read(int'(addr), n, uns));
        exp_lat = is_split(int'(addr), n) ? 2 : 1;
        read_op(acc, uns, addr, d, lat);
        exp = exp_q.pop_front();
        checks++; if (d !== exp || lat != exp_lat) begin
          failures++; $display("FAIL rnd_read t%0d addr %h size %0d uns %b: got %h lat %0d expected %h lat %0d", t, addr, n, uns, d, lat, exp, exp_lat);
        end
        last_rd = exp;
      end
    end
  endtask

  initial begin
    test_reset();
    init_mem();
    test_word_rw();
    test_extension();
    test_split();
    test_back_to_back();
    test_wrap();
    test_reserved();
    test_reset_split();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
